// File: rtl/photon_pkg.sv
// Shared definitions for the photon pulse generator: default widths and FSM encoding.
// Imported by the generator top and its phase timer.
package photon_pkg;

    localparam int COUNTSIZE_DEF = 32;
    localparam int LENSIZE_DEF   = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2,
        S_DONE = 2'd3
    } pg_state_e;

endpackage

// File: rtl/phase_timer.sv
// Down-counter timing one HIGH or LOW phase. A load starts a phase of len_i clocks
// (0 counts as 1); expire_o pulses during the last cycle of that phase.
module phase_timer #(
    parameter int LENSIZE = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  logic [LENSIZE-1:0] len_i,
    output logic               expire_o
);

    localparam logic [LENSIZE-1:0] ONE = LENSIZE'(1);

    logic [LENSIZE-1:0] cnt_q, cnt_d;
    logic               run_q, run_d;

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (load_i) begin
            run_d = 1'b1;
            // The counter holds the cycles remaining after the current one.
            cnt_d = (len_i == '0) ? '0 : (len_i - ONE);
        end else if (run_q) begin
            if (cnt_q == '0) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q - ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign expire_o = run_q && (cnt_q == '0);

endmodule

// File: rtl/photon_pulse_gen.sv
// Emits a train of g_pulse_num pulses with programmable high/low phase lengths on a
// registered g_ch1_out, with busy/done status, abort and a sent-pulse counter.
module photon_pulse_gen
    import photon_pkg::*;
#(
    parameter int COUNTSIZE = COUNTSIZE_DEF,
    parameter int LENSIZE   = LENSIZE_DEF
) (
    input  logic                 g_clk,
    input  logic                 g_rst,
    input  logic                 g_start,
    input  logic                 g_abort,
    input  logic [COUNTSIZE-1:0] g_pulse_num,
    input  logic [LENSIZE-1:0]   g_high_len,
    input  logic [LENSIZE-1:0]   g_low_len,
    output logic                 g_ch1_out,
    output logic                 g_busy,
    output logic                 g_done,
    output logic [COUNTSIZE-1:0] g_sent_cnt,
    output logic [1:0]           g_state_dbg
);

    localparam logic [COUNTSIZE-1:0] CNT_ONE = COUNTSIZE'(1);

    pg_state_e            state_q, state_d;
    logic [COUNTSIZE-1:0] num_q, num_d;
    logic [LENSIZE-1:0]   high_q, high_d;
    logic [LENSIZE-1:0]   low_q, low_d;
    logic [COUNTSIZE-1:0] sent_q, sent_d;
    logic                 ch1_q, busy_q, done_q;

    logic                 tmr_load;
    logic [LENSIZE-1:0]   tmr_len;
    logic                 tmr_expire;

    phase_timer #(
        .LENSIZE(LENSIZE)
    ) u_timer (
        .clk_i   (g_clk),
        .rst_i   (g_rst),
        .load_i  (tmr_load),
        .len_i   (tmr_len),
        .expire_o(tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        high_d   = high_q;
        low_d    = low_q;
        sent_d   = sent_q;
        tmr_load = 1'b0;
        tmr_len  = high_q;
        unique case (state_q)
            S_IDLE: begin
                // Abort is meaningless here, so a simultaneous start still wins.
                if (g_start) begin
                    num_d  = g_pulse_num;
                    high_d = g_high_len;
                    low_d  = g_low_len;
                    if (g_pulse_num != '0) begin
                        state_d  = S_HIGH;
                        sent_d   = CNT_ONE;
                        tmr_load = 1'b1;
                        tmr_len  = g_high_len;
                    end else begin
                        state_d = S_DONE;
                        sent_d  = '0;
                    end
                end
            end
            S_HIGH: begin
                if (g_abort) begin
                    state_d = S_IDLE;
                end else if (tmr_expire) begin
                    state_d  = S_LOW;
                    tmr_load = 1'b1;
                    tmr_len  = low_q;
                end
            end
            S_LOW: begin
                if (g_abort) begin
                    state_d = S_IDLE;
                end else if (tmr_expire) begin
                    // Equality test keeps a full-scale count from wrapping.
                    if (sent_q != num_q) begin
                        state_d  = S_HIGH;
                        sent_d   = sent_q + CNT_ONE;
                        tmr_load = 1'b1;
                        tmr_len  = high_q;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (g_rst) begin
            state_q <= S_IDLE;
            num_q   <= '0;
            high_q  <= '0;
            low_q   <= '0;
            sent_q  <= '0;
            ch1_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            high_q  <= high_d;
            low_q   <= low_d;
            sent_q  <= sent_d;
            ch1_q   <= (state_d == S_HIGH);
            busy_q  <= (state_d == S_HIGH) || (state_d == S_LOW);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign g_ch1_out   = ch1_q;
    assign g_busy      = busy_q;
    assign g_done      = done_q;
    assign g_sent_cnt  = sent_q;
    assign g_state_dbg = state_q;

endmodule

// File: tb/tb_photon_pulse_gen.sv
// Bench for photon_pulse_gen: directed vector table, hand sequences for reset/abort
// corners, and random trains checked cycle by cycle against a waveform model.
module tb_photon_pulse_gen;

  localparam int CW = 32;
  localparam int LW = 16;
  localparam int W  = 3 + CW;  // {ch1, busy, done, sent}

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort;
  logic [CW-1:0] num;
  logic [LW-1:0] hi, lo;
  logic          ch1, busy, done;
  logic [CW-1:0] sent;
  logic [1:0]    state_dbg;

  logic          fs_start;
  logic [3:0]    fs_num, fs_hi, fs_lo;
  logic          fs_ch1, fs_busy, fs_done;
  logic [3:0]    fs_sent;
  logic [1:0]    fs_state;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  photon_pulse_gen #(.COUNTSIZE(CW), .LENSIZE(LW)) u_dut (
    .g_clk(clk), .g_rst(rst), .g_start(start), .g_abort(abort),
    .g_pulse_num(num), .g_high_len(hi), .g_low_len(lo),
    .g_ch1_out(ch1), .g_busy(busy), .g_done(done),
    .g_sent_cnt(sent), .g_state_dbg(state_dbg)
  );

  // Narrow instance so a full-scale pulse count is reachable in simulation.
  photon_pulse_gen #(.COUNTSIZE(4), .LENSIZE(4)) u_dut_fs (
    .g_clk(clk), .g_rst(rst), .g_start(fs_start), .g_abort(1'b0),
    .g_pulse_num(fs_num), .g_high_len(fs_hi), .g_low_len(fs_lo),
    .g_ch1_out(fs_ch1), .g_busy(fs_busy), .g_done(fs_done),
    .g_sent_cnt(fs_sent), .g_state_dbg(fs_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic c, input logic b, input logic d, input int s);
    logic [CW-1:0] sv;
    sv = CW'(s);
    return {c, b, d, sv};
  endfunction

  // Expected waveform of one train starting at cycle 0: entry k is cycle k+1.
  task automatic build_model(input int n, input int h, input int l);
    int he, le;
    he = (h == 0) ? 1 : h;
    le = (l == 0) ? 1 : l;
    exp_q.delete();
    for (int p = 1; p <= n; p++) begin
      for (int i = 0; i < he; i++) exp_q.push_back(pack(1'b1, 1'b1, 1'b0, p));
      for (int i = 0; i < le; i++) exp_q.push_back(pack(1'b0, 1'b1, 1'b0, p));
    end
    exp_q.push_back(pack(1'b0, 1'b0, 1'b1, n));
  endtask

  // Cut the model at an abort seen during cycle abort_at (only if busy then).
  task automatic apply_abort(input int abort_at);
    logic [W-1:0] e;
    if (abort_at > 0 && abort_at <= exp_q.size()) begin
      e = exp_q[abort_at-1];
      if (e[W-2]) begin
        while (exp_q.size() > abort_at) void'(exp_q.pop_back());
        exp_q.push_back(pack(1'b0, 1'b0, 1'b0, int'(e[CW-1:0])));
      end
    end
  endtask

  task automatic run_train(input int n, input int h, input int l, input int abort_at,
                           input int extra_start, output int done_cyc,
                           output int sent_final, output int rises);
    logic [W-1:0] e, tail;
    int len;
    logic prev;
    build_model(n, h, l);
    apply_abort(abort_at);
    tail = exp_q[exp_q.size()-1];
    tail[W-3] = 1'b0;
    exp_q.push_back(tail);
    exp_q.push_back(tail);
    len = exp_q.size();
    done_cyc = -1;
    rises = 0;
    num = CW'(n); hi = LW'(h); lo = LW'(l);
    start = 1'b1;
    prev = ch1;
    for (int c = 1; c <= len; c++) begin
      step();
      start = 1'b0;
      abort = 1'b0;
      e = exp_q.pop_front();
      check("cycle_outputs", 64'({ch1, busy, done, sent}), 64'(e));
      if (done && done_cyc < 0) done_cyc = c;
      if (ch1 && !prev) rises++;
      prev = ch1;
      if (c == abort_at) abort = 1'b1;
      if (c == extra_start) start = 1'b1;
    end
    sent_final = int'(sent);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int num; int hi; int lo; int abort_at; int extra_start;
    int exp_done; int exp_sent; int exp_rises;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int dcyc, sfin, nr;
    int n, h, l, ab, xs, t;

    vecs[0] = '{3, 2, 3, -1, -1, 16, 3, 3};
    vecs[1] = '{0, 2, 3, -1, -1, 1, 0, 0};
    vecs[2] = '{2, 0, 0, -1, -1, 5, 2, 2};
    vecs[3] = '{5, 4, 4, 10, -1, -1, 2, 2};
    vecs[4] = '{1, 1, 1, -1, 2, 3, 1, 1};
    vecs[5] = '{4, 1, 2, -1, 5, 13, 4, 4};
    vecs[6] = '{1000, 1, 1, -1, -1, 2001, 1000, 1000};

    rst = 1'b1; start = 1'b0; abort = 1'b0; num = '0; hi = '0; lo = '0;
    fs_start = 1'b0; fs_num = '0; fs_hi = '0; fs_lo = '0;
    step(); step();
    rst = 1'b0;
    check("reset_outputs", 64'({ch1, busy, done, sent}), 64'(0));
    check("reset_state", 64'(state_dbg), 64'(0));
    check("reset_fs_outputs", 64'({fs_ch1, fs_busy, fs_done, fs_sent}), 64'(0));
    step();

    for (int i = 0; i < 7; i++) begin
      run_train(vecs[i].num, vecs[i].hi, vecs[i].lo, vecs[i].abort_at,
                vecs[i].extra_start, dcyc, sfin, nr);
      check("vec_done_cycle", 64'(dcyc), 64'(vecs[i].exp_done));
      check("vec_sent", 64'(sfin), 64'(vecs[i].exp_sent));
      check("vec_photon_count", 64'(nr), 64'(vecs[i].exp_rises));
    end

    // Mid-train reset with ignored starts, then a fresh start.
    build_model(4, 3, 3);
    num = 4; hi = 3; lo = 3; start = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      step();
      start = 1'b0;
      rst = 1'b0;
      if (c <= 8) check("rst_seq_pre", 64'({ch1, busy, done, sent}), 64'(exp_q.pop_front()));
      if (c == 9 || c == 10) begin
        check("rst_seq_cleared", 64'({ch1, busy, done, sent}), 64'(0));
        check("rst_seq_state", 64'(state_dbg), 64'(0));
      end
      if (c == 11) check("rst_seq_restart", 64'({ch1, busy, done, sent}), 64'(pack(1'b1, 1'b1, 1'b0, 1)));
      if (c == 2 || c == 5 || c == 10) start = 1'b1;
      if (c == 8) rst = 1'b1;
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_during_train", 64'({ch1, busy, done, sent}), 64'(pack(1'b0, 1'b0, 1'b0, 1)));

    // Abort alone in IDLE does nothing; abort together with start still starts.
    abort = 1'b1;
    step();
    check("abort_idle_noeffect", 64'({ch1, busy, done, sent, state_dbg}),
          64'({pack(1'b0, 1'b0, 1'b0, 1), 2'd0}));
    num = 2; hi = 1; lo = 1; start = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("abort_start_idle", 64'({ch1, busy, done, sent}), 64'(pack(1'b1, 1'b1, 1'b0, 1)));
    repeat (6) step();
    check("abort_start_idle_end", 64'({ch1, busy, done, sent}), 64'(pack(1'b0, 1'b0, 1'b0, 2)));

    // Full-scale count on the narrow instance must finish at 15, never wrapping.
    begin
      int fs_done_cyc;
      int fs_wrap;
      logic [3:0] last;
      fs_done_cyc = -1; fs_wrap = 0; last = '0;
      fs_num = 4'hF; fs_hi = 4'h0; fs_lo = 4'h0; fs_start = 1'b1;
      for (int c = 1; c <= 40; c++) begin
        step();
        fs_start = 1'b0;
        if (fs_sent < last) fs_wrap++;
        last = fs_sent;
        if (fs_done && fs_done_cyc < 0) fs_done_cyc = c;
      end
      check("fullscale_done_cycle", 64'(fs_done_cyc), 64'(31));
      check("fullscale_sent", 64'(fs_sent), 64'(15));
      check("fullscale_no_wrap", 64'(fs_wrap), 64'(0));
    end

    // Random trains with optional abort and ignored extra starts.
    for (int k = 0; k < 40; k++) begin
      n = $urandom_range(0, 6);
      h = $urandom_range(0, 4);
      l = $urandom_range(0, 4);
      t = (n == 0) ? 1 : n * (((h == 0) ? 1 : h) + ((l == 0) ? 1 : l)) + 1;
      ab = -1;
      if (n > 0 && $urandom_range(0, 2) == 0) ab = $urandom_range(1, t - 1);
      xs = -1;
      if ($urandom_range(0, 1) == 1) xs = $urandom_range(1, (ab > 0) ? ab : t);
      run_train(n, h, l, ab, xs, dcyc, sfin, nr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/photon_pulse_gen.md
PHOTON_PULSE_GEN -- requirements
Module: photon_pulse_gen

Interface
REQ-001 Parameter COUNTSIZE, default 32: width of pulse-count request and sent counter.
REQ-002 Parameter LENSIZE, default 16: width of high/low phase length fields.
REQ-003 g_clk  in  1  sole clock; all logic on rising edge.
REQ-004 g_rst  in  1  reset; synchronous, active-high.
REQ-005 g_start  in  1  single-cycle request to begin a pulse train.
REQ-006 g_abort  in  1  terminate the current train.
REQ-007 g_pulse_num  in  COUNTSIZE  number of pulses to emit; sampled on accepted start.
REQ-008 g_high_len  in  LENSIZE  high-phase length in clocks; sampled on accepted start.
REQ-009 g_low_len  in  LENSIZE  low-phase length in clocks; sampled on accepted start.
REQ-010 g_ch1_out  out  1  registered pulse output, compatible with the photon counter's g_ch1 input.
REQ-011 g_busy  out  1  high while a train is in progress.
REQ-012 g_done  out  1  one-cycle completion strobe.
REQ-013 g_sent_cnt  out  COUNTSIZE  pulses emitted in the current or most recent train.

Function
REQ-014 The FSM SHALL have states IDLE, HIGH, LOW and DONE.
REQ-015 In IDLE, g_start=1 SHALL be accepted: latch num/high/low and clear g_sent_cnt.
- If num!=0, enter HIGH next cycle.
- If num=0, enter DONE next cycle.
REQ-016 g_start SHALL be ignored in HIGH, LOW and DONE.
REQ-017 A latched length of 0 SHALL be treated as 1.
REQ-018 g_ch1_out SHALL be 1 exactly while the FSM is in HIGH and 0 in all other states, with no combinational path from inputs.
REQ-019 HIGH SHALL last high_len cycles, then go to LOW. LOW SHALL last low_len cycles.
REQ-020 At the end of LOW, the FSM SHALL return to HIGH if pulses remain, else go to DONE.
REQ-021 g_sent_cnt SHALL increment by 1 on the first cycle of each HIGH phase; it is held after completion until the next accepted start.
REQ-022 The first rising edge of g_ch1_out SHALL appear on the cycle immediately after start acceptance (latency 1).
REQ-023 DONE SHALL last exactly one cycle with g_done=1, then go to IDLE.
REQ-024 g_busy SHALL be 1 in HIGH and LOW only.
REQ-025 g_abort=1 in HIGH or LOW SHALL force IDLE on the next edge.
- g_ch1_out goes 0; g_done is not asserted; g_sent_cnt is held.
- Abort takes priority over every phase transition.
REQ-026 g_abort SHALL have no effect in IDLE or DONE. If g_abort and g_start are both high in IDLE, the start SHALL still be accepted.
REQ-027 g_sent_cnt SHALL never exceed the latched num; full-scale num (all ones) SHALL complete without wrap.

Reset
REQ-028 g_rst=1 at any rising edge, including mid-train, SHALL force state IDLE and clear all outputs and internal counters to 0.
- Cleared outputs: g_ch1_out=0, g_busy=0, g_done=0, g_sent_cnt=0.
REQ-029 g_rst SHALL take priority over g_start and g_abort.

Structure
REQ-030 FSM state encodings and the default COUNTSIZE/LENSIZE values SHALL reside in the shared package photon_pkg.
REQ-031 The phase-length down-counter SHALL be one sub-module, phase_timer.
- Inputs: load strobe and length.
- Output: one-cycle expire strobe.
- Used for both HIGH and LOW phases.

Verification
REQ-032 Nominal train: start at cycle 0 with num=3, high=2, low=3.
- g_ch1_out=1 on cycles 1-2, 6-7 and 11-12, else 0.
- g_done=1 on cycle 16 only; g_sent_cnt=3; g_busy=1 on cycles 1-15.
REQ-033 Zero count: num=0 -> g_done=1 on cycle 1, g_ch1_out stays 0, g_busy stays 0, g_sent_cnt=0.
REQ-034 Zero length: num=2, high=0, low=0 -> g_ch1_out=1,0,1,0 on cycles 1-4; g_done on cycle 5.
REQ-035 Mid-train abort: num=5, high=4, low=4, abort asserted on cycle 10 (in HIGH of pulse 2).
- From cycle 11: IDLE, g_ch1_out=0, g_done never asserts, g_sent_cnt=2.
REQ-036 Mid-train reset and start-while-busy: num=4, high=3, low=3; extra g_start pulses on cycles 2 and 5 are ignored.
- Sync reset on cycle 8 -> on cycle 9 all outputs are 0.
- A start on cycle 10 produces its first pulse on cycle 11.
REQ-037 Loopback: connect g_ch1_out to a photon_counter instance and emit num=1000, high=1, low=1.
- Counter reads 1000 after g_done, and g_sent_cnt=1000.
